// File: rtl/multicore_pkg.sv
// Shared sizing and slot record for the rede_float core-bank scheduler.
package multicore_pkg;
    localparam int N_CORES     = 21;
    localparam int DATA_W      = 28;
    localparam int EN_W        = 4;
    localparam int STAGGER_DEF = 24;
    localparam int CORE_ID_W   = $clog2(N_CORES);

    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic [EN_W-1:0]          en;
    } slot_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N    = 21,
    parameter int ID_W = 5
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // N is not a power of two, so the wrap is an explicit subtract
        for (int off = 0; off < N; off++) begin
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/multicore_sched.sv
// Staggered core-reset release, per-core 1-deep result capture and round-robin drain
// onto a single valid/ready result stream.
module multicore_sched
    import multicore_pkg::*;
#(
    parameter int STAGGER = STAGGER_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [N_CORES-1:0]        core_rst,
    input  logic [N_CORES*DATA_W-1:0] core_io_out,
    input  logic [N_CORES*EN_W-1:0]   core_out_en,
    output logic signed [DATA_W-1:0]  m_data,
    output logic [EN_W-1:0]           m_tag,
    output logic [CORE_ID_W-1:0]      m_core,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      all_running,
    output logic [N_CORES-1:0]        ovf
);
    localparam int IDX_W = $clog2(N_CORES + 1);
    localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    logic [N_CORES-1:0]   core_rst_q;
    logic [CNT_W-1:0]     stag_cnt;
    logic [IDX_W-1:0]     rel_idx;
    logic                 release_now;

    slot_t                slot_q [N_CORES];
    logic [N_CORES-1:0]   full_q;
    logic [N_CORES-1:0]   ovf_q;
    logic [N_CORES-1:0]   cap;
    logic [N_CORES-1:0]   drain;
    logic [N_CORES-1:0]   grant;
    logic [CORE_ID_W-1:0] win_idx;
    logic                 win_any;
    logic                 out_load;
    logic                 out_free;
    logic [CORE_ID_W-1:0] rr_ptr;

    assign core_rst = core_rst_q;
    assign ovf      = ovf_q;

    // Release sequencer: core 0 goes on the first edge out of reset, then one per STAGGER edges
    assign release_now = (rel_idx < IDX_W'(N_CORES)) &&
                         ((rel_idx == '0) || (stag_cnt == CNT_W'(STAGGER - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_q  <= '1;
            stag_cnt    <= '0;
            rel_idx     <= '0;
            all_running <= 1'b0;
        end else if (rel_idx < IDX_W'(N_CORES)) begin
            if (release_now) begin
                core_rst_q[rel_idx] <= 1'b0;
                rel_idx             <= rel_idx + 1'b1;
                stag_cnt            <= '0;
                if (rel_idx == IDX_W'(N_CORES - 1)) all_running <= 1'b1;
            end else begin
                stag_cnt <= stag_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cap = '0;
        for (int i = 0; i < N_CORES; i++)
            cap[i] = !core_rst_q[i] && (core_out_en[i*EN_W +: EN_W] != '0);
    end

    rr_arbiter #(
        .N    (N_CORES),
        .ID_W (CORE_ID_W)
    ) u_arb (
        .req   (full_q),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign out_free = !m_valid || m_ready;
    assign out_load = out_free && win_any;
    assign drain    = out_load ? grant : '0;

    // Slot occupancy and sticky overflow; a drained slot may be refilled on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (cap[i]) begin
                    if (full_q[i] && !drain[i]) ovf_q[i] <= 1'b1;
                    else                        full_q[i] <= 1'b1;
                end else if (drain[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (cap[i] && !(full_q[i] && !drain[i])) begin
                slot_q[i].data <= core_io_out[i*DATA_W +: DATA_W];
                slot_q[i].en   <= core_out_en[i*EN_W +: EN_W];
            end
        end
    end

    // Output register holds while stalled; pointer advances past each winner
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_tag   <= '0;
            m_core  <= '0;
            rr_ptr  <= '0;
        end else if (out_free) begin
            if (win_any) begin
                m_valid <= 1'b1;
                m_data  <= slot_q[win_idx].data;
                m_tag   <= slot_q[win_idx].en;
                m_core  <= win_idx;
                rr_ptr  <= (win_idx == CORE_ID_W'(N_CORES - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multicore_sched.sv
// Directed bench for multicore_sched: release stagger, capture/drain order, stall, overflow, reset.
module tb_multicore_sched;
    localparam int N  = 21;
    localparam int DW = 28;
    localparam int EW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      core_rst;
    logic [N*DW-1:0]   core_io_out = '0;
    logic [N*EW-1:0]   core_out_en = '0;
    logic signed [DW-1:0] m_data;
    logic [EW-1:0]     m_tag;
    logic [4:0]        m_core;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              all_running;
    logic [N-1:0]      ovf;

    int errors = 0;
    int checks = 0;

    multicore_sched #(.STAGGER(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_rst    (core_rst),
        .core_io_out (core_io_out),
        .core_out_en (core_out_en),
        .m_data      (m_data),
        .m_tag       (m_tag),
        .m_core      (m_core),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .all_running (all_running),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic signed [DW-1:0] d, input logic [EW-1:0] e);
        core_io_out[i*DW +: DW] = d;
        core_out_en[i*EW +: EW] = e;
    endtask

    task automatic clear_cores();
        core_io_out = '0;
        core_out_en = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b1;
        clear_cores();
        repeat (3) step();
        checks++; if (core_rst !== {N{1'b1}}) begin errors++; $display("FAIL reset_core_rst got=%h exp=%h", core_rst, {N{1'b1}}); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== '0 || m_tag !== '0 || m_core !== '0) begin errors++; $display("FAIL reset_m_fields got=%h/%h/%h exp=0/0/0", m_data, m_tag, m_core); end
        checks++; if (all_running !== 1'b0) begin errors++; $display("FAIL reset_all_running got=%b exp=0", all_running); end
        checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf got=%h exp=0", ovf); end
    endtask

    task automatic test_in_reset_ignore();
        rst = 1'b0;
        step();
        step();
        set_core(7, 28'sd99, 4'd3);
        step();
        clear_cores();
        for (int c = 0; c < 3; c++) begin
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL held_core_valid cyc=%0d got=%b exp=0", c, m_valid); end
            step();
        end
        checks++; if (ovf !== '0) begin errors++; $display("FAIL held_core_ovf got=%h exp=0", ovf); end
        checks++; if (core_rst[7] !== 1'b1) begin errors++; $display("FAIL held_core_rst7 got=%b exp=1", core_rst[7]); end
    endtask

    task automatic test_release();
        logic [N-1:0] exp_rst;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int c = 1; c <= 500; c++) begin
            step();
            exp_rst = '1;
            for (int i = 0; i < N; i++) if (c >= 1 + 24*i) exp_rst[i] = 1'b0;
            checks++; if (core_rst !== exp_rst) begin errors++; $display("FAIL release_core_rst c=%0d got=%h exp=%h", c, core_rst, exp_rst); end
            checks++; if (all_running !== (c >= 481)) begin errors++; $display("FAIL release_all_running c=%0d got=%b exp=%b", c, all_running, (c >= 481)); end
        end
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        set_core(3, -28'sd5, 4'd1);
        step();
        clear_cores();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", m_valid); end
        step();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== -28'sd5) begin errors++; $display("FAIL single_data got=%0d exp=-5", m_data); end
        checks++; if (m_tag !== 4'd1) begin errors++; $display("FAIL single_tag got=%0d exp=1", m_tag); end
        checks++; if (m_core !== 5'd3) begin errors++; $display("FAIL single_core got=%0d exp=3", m_core); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%b exp=0", m_valid); end
    endtask

    task automatic test_rr_order();
        m_ready = 1'b1;
        set_core(5, 28'sd1, 4'd2);
        step();
        clear_cores();
        step();
        checks++; if (m_core !== 5'd5 || m_valid !== 1'b1) begin errors++; $display("FAIL rr_setup got=%0d/%b exp=5/1", m_core, m_valid); end
        step();
        set_core(0, 28'sd10, 4'd1);
        set_core(5, 28'sd50, 4'd5);
        set_core(20, -28'sd200, 4'd15);
        step();
        clear_cores();
        step();
        checks++; if (m_core !== 5'd20 || m_data !== -28'sd200 || m_tag !== 4'd15) begin errors++; $display("FAIL rr_first got=%0d/%0d/%0d exp=20/-200/15", m_core, m_data, m_tag); end
        step();
        checks++; if (m_core !== 5'd0 || m_data !== 28'sd10 || m_tag !== 4'd1) begin errors++; $display("FAIL rr_second got=%0d/%0d/%0d exp=0/10/1", m_core, m_data, m_tag); end
        step();
        checks++; if (m_core !== 5'd5 || m_data !== 28'sd50 || m_tag !== 4'd5) begin errors++; $display("FAIL rr_third got=%0d/%0d/%0d exp=5/50/5", m_core, m_data, m_tag); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got=%b exp=0", m_valid); end
    endtask

    task automatic test_stall_overflow();
        m_ready = 1'b0;
        set_core(2, 28'sd1000, 4'd2);
        step();
        clear_cores();
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 28'sd1000 || m_core !== 5'd2) begin errors++; $display("FAIL stall_first got=%b/%0d/%0d exp=1/1000/2", m_valid, m_data, m_core); end
        set_core(2, -28'sd2000, 4'd5);
        step();
        clear_cores();
        checks++; if (m_data !== 28'sd1000 || m_tag !== 4'd2) begin errors++; $display("FAIL stall_hold got=%0d/%0d exp=1000/2", m_data, m_tag); end
        set_core(2, 28'sd777, 4'd6);
        step();
        clear_cores();
        checks++; if (ovf !== 21'h4) begin errors++; $display("FAIL ovf_set got=%h exp=000004", ovf); end
        checks++; if (m_valid !== 1'b1 || m_data !== 28'sd1000) begin errors++; $display("FAIL ovf_hold got=%b/%0d exp=1/1000", m_valid, m_data); end
        m_ready = 1'b1;
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== -28'sd2000 || m_tag !== 4'd5 || m_core !== 5'd2) begin errors++; $display("FAIL stall_second got=%b/%0d/%0d/%0d exp=1/-2000/5/2", m_valid, m_data, m_tag, m_core); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_no_third got=%b data=%0d exp=0", m_valid, m_data); end
        checks++; if (ovf !== 21'h4) begin errors++; $display("FAIL ovf_sticky got=%h exp=000004", ovf); end
    endtask

    task automatic test_mid_reset();
        m_ready = 1'b0;
        set_core(1, 28'sd11, 4'd1);
        set_core(4, 28'sd44, 4'd4);
        step();
        clear_cores();
        step();
        checks++; if (m_valid !== 1'b1 || m_core !== 5'd4) begin errors++; $display("FAIL midrst_pre got=%b/%0d exp=1/4", m_valid, m_core); end
        rst = 1'b1;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", m_valid); end
        checks++; if (core_rst !== {N{1'b1}}) begin errors++; $display("FAIL midrst_core_rst got=%h exp=%h", core_rst, {N{1'b1}}); end
        checks++; if (ovf !== '0 || all_running !== 1'b0) begin errors++; $display("FAIL midrst_ovf_run got=%h/%b exp=0/0", ovf, all_running); end
        rst = 1'b0;
        m_ready = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step();
            checks++;
            if (core_rst !== ((c >= 25) ? 21'h1FFFFC : 21'h1FFFFE)) begin
                errors++;
                $display("FAIL replay_core_rst c=%0d got=%h exp=%h", c, core_rst, (c >= 25) ? 21'h1FFFFC : 21'h1FFFFE);
            end
            if (c == 3) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL replay_discard got=%b exp=0", m_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_reset_ignore();
        test_release();
        test_single();
        test_rr_order();
        test_stall_overflow();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
